// File: rtl/red_pitaya_pll_supervisor_if.sv
// Control and status bundle between the PLL supervisor and its environment.
// The supervisor uses the slave view; the environment that drives lock status
// and software requests uses the master view.
interface red_pitaya_pll_supervisor_if;
  logic        pll_locked;
  logic        sw_rst_req;
  logic        timeout_clr;
  logic        pll_rst;
  logic        rstn_out;
  logic        lock_ok;
  logic [1:0]  state_o;
  logic [15:0] lol_cnt;
  logic        timeout_flag;

  modport master (
    output pll_locked, sw_rst_req, timeout_clr,
    input  pll_rst, rstn_out, lock_ok, state_o, lol_cnt, timeout_flag
  );

  modport slave (
    input  pll_locked, sw_rst_req, timeout_clr,
    output pll_rst, rstn_out, lock_ok, state_o, lol_cnt, timeout_flag
  );
endinterface

// File: rtl/red_pitaya_pll_supervisor.sv
// PLL bring-up supervisor: holds the PLL in reset, waits for a stable lock,
// then releases the reset of the PLL-clocked domain. Loss of lock in RUN
// restarts the sequence and is counted; lock timeouts raise a sticky flag.
module red_pitaya_pll_supervisor #(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536
) (
  input logic                         clk,
  input logic                         rstn,
  red_pitaya_pll_supervisor_if.slave  bus
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts: the transition fires on the edge where the counter
  // holds N-1, so each state lasts exactly N counted edges.
  localparam logic [20:0] RST_LAST = 21'(PLL_RST_CYC - 1);
  localparam logic [20:0] STB_LAST = 21'(LOCK_STABLE_CYC - 1);
  localparam logic [20:0] TMO_LAST = 21'(LOCK_TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_next;
  logic [20:0] cnt;
  logic [20:0] cnt_next;
  logic        sync1;
  logic        lock_s;
  logic        timeout_hit;
  logic        lol_hit;
  logic        pll_rst_q;
  logic        rstn_out_q;
  logic        lock_ok_q;
  logic        timeout_flag_q;
  logic [15:0] lol_cnt_q;

  // Two-flop synchroniser: the only place pll_locked is sampled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_locked;
      lock_s <= sync1;
    end
  end

  // Next-state and shared-counter logic; software request overrides all.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 21'd1;
    timeout_hit = 1'b0;
    lol_hit     = 1'b0;
    if (bus.sw_rst_req) begin
      state_next = PLL_RST;
      cnt_next   = '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt == TMO_LAST) begin
            state_next  = PLL_RST;
            cnt_next    = '0;
            timeout_hit = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == STB_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end
        RUN: begin
          cnt_next = '0;
          if (!lock_s) begin
            state_next = PLL_RST;
            lol_hit    = 1'b1;
          end
        end
        default: begin
          state_next = PLL_RST;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pll_rst_q  <= 1'b1;
      rstn_out_q <= 1'b0;
      lock_ok_q  <= 1'b0;
    end else begin
      pll_rst_q  <= (state_next == PLL_RST);
      rstn_out_q <= (state_next == RUN);
      lock_ok_q  <= (state_next == RUN);
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_flag_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_flag_q <= 1'b1;
    end else if (bus.timeout_clr) begin
      timeout_flag_q <= 1'b0;
    end
  end

  // Saturating loss-of-lock counter, cleared only by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lol_cnt_q <= '0;
    end else if (lol_hit && (lol_cnt_q != 16'hFFFF)) begin
      lol_cnt_q <= lol_cnt_q + 16'd1;
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.rstn_out     = rstn_out_q;
  assign bus.lock_ok      = lock_ok_q;
  assign bus.state_o      = state;
  assign bus.lol_cnt      = lol_cnt_q;
  assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_red_pitaya_pll_supervisor.sv
// Directed bench for red_pitaya_pll_supervisor with PLL_RST_CYC=4,
// LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32. Edge numbers in the comments are
// relative to the marked reference edge of each step.
module tb_red_pitaya_pll_supervisor;

  logic clk;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  red_pitaya_pll_supervisor_if bus();

  red_pitaya_pll_supervisor #(
    .PLL_RST_CYC      (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 100 MHz reference clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn            = 1'b1;
    bus.pll_locked  = 1'b0;
    bus.sw_rst_req  = 1'b0;
    bus.timeout_clr = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check("rst_state",    32'(bus.state_o), 32'd0);
    check("rst_pll_rst",  32'(bus.pll_rst), 32'd1);
    check("rst_rstn_out", 32'(bus.rstn_out), 32'd0);
    check("rst_lock_ok",  32'(bus.lock_ok), 32'd0);
    check("rst_lol_cnt",  32'(bus.lol_cnt), 32'd0);
    check("rst_tflag",    32'(bus.timeout_flag), 32'd0);
    tick(2);

    // Nominal bring-up: edge 1 is the first edge with rstn high.
    rstn = 1'b1;
    tick(3);                                    // edge 3
    check("bring_hold_e3",  32'(bus.pll_rst), 32'd1);
    check("bring_state_e3", 32'(bus.state_o), 32'd0);
    tick(1);                                    // edge 4
    check("bring_pllrst_e4", 32'(bus.pll_rst), 32'd0);
    check("bring_state_e4",  32'(bus.state_o), 32'd1);
    tick(5);                                    // edge 9
    bus.pll_locked = 1'b1;                      // sampled at edge 10
    tick(10);                                   // edge 19
    check("bring_state_e19", 32'(bus.state_o), 32'd2);
    check("bring_rstn_e19",  32'(bus.rstn_out), 32'd0);
    tick(1);                                    // edge 20
    check("bring_rstn_e20",  32'(bus.rstn_out), 32'd1);
    check("bring_state_e20", 32'(bus.state_o), 32'd3);
    check("bring_lockok",    32'(bus.lock_ok), 32'd1);
    check("bring_pllrst",    32'(bus.pll_rst), 32'd0);

    // Software restart from RUN (edge S), then a second request restarts the hold.
    bus.sw_rst_req = 1'b1;
    tick(1);                                    // S
    bus.sw_rst_req = 1'b0;
    check("sw_state",   32'(bus.state_o), 32'd0);
    check("sw_pllrst",  32'(bus.pll_rst), 32'd1);
    check("sw_rstnout", 32'(bus.rstn_out), 32'd0);
    check("sw_lockok",  32'(bus.lock_ok), 32'd0);
    check("sw_lolcnt",  32'(bus.lol_cnt), 32'd0);
    tick(1);                                    // S+1
    bus.sw_rst_req = 1'b1;
    tick(1);                                    // S+2, hold restarts
    bus.sw_rst_req = 1'b0;
    tick(2);                                    // S+4
    check("sw_hold_s4", 32'(bus.pll_rst), 32'd1);
    tick(1);                                    // S+5
    check("sw_hold_s5", 32'(bus.pll_rst), 32'd1);
    tick(1);                                    // S+6
    check("sw_rel_s6",   32'(bus.pll_rst), 32'd0);
    check("sw_state_s6", 32'(bus.state_o), 32'd1);
    tick(1);                                    // S+7
    check("sw_stable_s7", 32'(bus.state_o), 32'd2);

    // One-cycle lock glitch while in STABLE.
    tick(2);                                    // S+9
    bus.pll_locked = 1'b0;
    tick(1);                                    // S+10
    bus.pll_locked = 1'b1;                      // re-rise sampled at S+11
    tick(2);                                    // S+12
    check("glitch_wait",   32'(bus.state_o), 32'd1);
    tick(1);                                    // S+13
    check("glitch_stable", 32'(bus.state_o), 32'd2);
    tick(7);                                    // S+20
    check("glitch_rstn_s20", 32'(bus.rstn_out), 32'd0);
    tick(1);                                    // S+21
    check("glitch_rstn_s21", 32'(bus.rstn_out), 32'd1);
    check("glitch_run",      32'(bus.state_o), 32'd3);
    check("glitch_lolcnt",   32'(bus.lol_cnt), 32'd0);

    // Loss of lock in RUN: lock drops after edge L.
    bus.pll_locked = 1'b0;
    tick(2);                                    // L+2
    check("lol_rstn_l2", 32'(bus.rstn_out), 32'd1);
    tick(1);                                    // L+3
    check("lol_rstn_l3",   32'(bus.rstn_out), 32'd0);
    check("lol_lockok_l3", 32'(bus.lock_ok), 32'd0);
    check("lol_pllrst_l3", 32'(bus.pll_rst), 32'd1);
    check("lol_state_l3",  32'(bus.state_o), 32'd0);
    check("lol_cnt_l3",    32'(bus.lol_cnt), 32'd1);
    tick(3);                                    // L+6
    check("lol_hold_l6", 32'(bus.pll_rst), 32'd1);
    tick(1);                                    // L+7
    check("lol_rel_l7",   32'(bus.pll_rst), 32'd0);
    check("lol_state_l7", 32'(bus.state_o), 32'd1);

    // Lock timeout with pll_locked held low.
    tick(31);                                   // L+38
    check("tmo_state_l38", 32'(bus.state_o), 32'd1);
    check("tmo_flag_l38",  32'(bus.timeout_flag), 32'd0);
    tick(1);                                    // L+39
    check("tmo_state_l39",  32'(bus.state_o), 32'd0);
    check("tmo_pllrst_l39", 32'(bus.pll_rst), 32'd1);
    check("tmo_flag_l39",   32'(bus.timeout_flag), 32'd1);
    tick(3);                                    // L+42
    check("tmo_hold_l42", 32'(bus.pll_rst), 32'd1);
    tick(1);                                    // L+43
    check("tmo_rel_l43", 32'(bus.pll_rst), 32'd0);
    tick(1);                                    // L+44
    bus.timeout_clr = 1'b1;
    tick(1);                                    // L+45
    bus.timeout_clr = 1'b0;
    check("tmo_clr_l45", 32'(bus.timeout_flag), 32'd0);
    tick(29);                                   // L+74
    check("tmo_pllrst_l74", 32'(bus.pll_rst), 32'd0);
    check("tmo_state_l74",  32'(bus.state_o), 32'd1);
    bus.timeout_clr = 1'b1;                     // coincides with second timeout
    tick(1);                                    // L+75
    bus.timeout_clr = 1'b0;
    check("tmo_setwins",    32'(bus.timeout_flag), 32'd1);
    check("tmo_pllrst_l75", 32'(bus.pll_rst), 32'd1);

    // Saturation of the loss-of-lock counter.
    bus.pll_locked = 1'b1;
    tick(13);                                   // L+88
    check("sat_run", 32'(bus.state_o), 32'd3);
    force dut.lol_cnt_q = 16'hFFFF;
    #1;
    release dut.lol_cnt_q;
    #1;
    check("sat_preload", 32'(bus.lol_cnt), 32'hFFFF);
    bus.pll_locked = 1'b0;
    tick(3);                                    // M
    check("sat_state",  32'(bus.state_o), 32'd0);
    check("sat_pllrst", 32'(bus.pll_rst), 32'd1);
    check("sat_lolcnt", 32'(bus.lol_cnt), 32'hFFFF);

    // Asynchronous reset while in STABLE.
    bus.pll_locked = 1'b1;
    tick(6);                                    // M+6
    check("arst_pre_stable", 32'(bus.state_o), 32'd2);
    #2 rstn = 1'b0;
    #1;
    check("arst_state",   32'(bus.state_o), 32'd0);
    check("arst_pllrst",  32'(bus.pll_rst), 32'd1);
    check("arst_rstnout", 32'(bus.rstn_out), 32'd0);
    check("arst_lockok",  32'(bus.lock_ok), 32'd0);
    check("arst_lolcnt",  32'(bus.lol_cnt), 32'd0);
    check("arst_tflag",   32'(bus.timeout_flag), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
